// File: rtl/rosc_harvester_pkg.sv
`default_nettype none
// =============================================================================
// Package  : rosc_harvester_pkg
// Brief    : Register map of the ring-oscillator entropy core and bus helpers.
// Revision : 1.0 - initial release
// =============================================================================
package rosc_harvester_pkg;

    // Shared with the entropy core; keep both sides identical.
    localparam logic [7:0] ADDR_STATUS      = 8'h09;
    localparam logic [7:0] ADDR_ENTROPY     = 8'h20;
    localparam logic [7:0] ADDR_NONE        = 8'h00;
    localparam int         STATUS_READY_BIT = 0;

    function automatic logic status_ready(input logic [31:0] status_word);
        return status_word[STATUS_READY_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/harvest_fifo.sv
`default_nettype none
// =============================================================================
// Module   : harvest_fifo
// Brief    : Synchronous first-word-fall-through FIFO, DEPTH a power of 2 (>=2).
// Revision : 1.0 - initial release
// =============================================================================
module harvest_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    // Head word is forced to zero while empty so stale storage never leaks out.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/rosc_harvester.sv
`default_nettype none
// =============================================================================
// Module   : rosc_harvester
// Brief    : Polls the ring-oscillator entropy core, health-tests and buffers words.
// Revision : 1.0 - initial release
// =============================================================================
module rosc_harvester #(
    parameter logic [15:0] POLL_CYCLES   = 16'h0100,
    parameter int          DISCARD_WORDS = 4,
    parameter int          REP_LIMIT     = 3,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rosc_cs,
    output logic        rosc_we,
    output logic [7:0]  rosc_address,
    output logic [31:0] rosc_write_data,
    input  logic [31:0] rosc_read_data,
    input  logic        rosc_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        health_error
);

    import rosc_harvester_pkg::*;

    localparam int DW = (DISCARD_WORDS > 0) ? $clog2(DISCARD_WORDS + 1) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] c_rep_trip = RW'(REP_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STATUS  = 2'd2,
        ST_ENTROPY = 2'd3
    } state_t;

    state_t         r_state;
    logic [15:0]    r_poll_ctr;
    logic           r_gap;
    logic           r_cap_valid;
    logic [31:0]    r_cap_word;
    logic [DW-1:0]  r_discard_ctr;
    logic [RW-1:0]  r_rep_ctr;
    logic [31:0]    r_last_word;
    logic           r_health_error;
    logic [RW-1:0]  w_rep_next;
    logic           w_push;
    logic           w_fifo_full;
    logic           w_fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_poll_ctr  <= '0;
            r_gap       <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_word  <= '0;
        end else begin
            r_cap_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A word still waiting to be pushed may fill the FIFO or trip the health test.
                    if (enable && !r_health_error && !w_fifo_full && !r_cap_valid) begin
                        r_state    <= ST_WAIT;
                        r_poll_ctr <= POLL_CYCLES - 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_poll_ctr == 16'd0) begin
                        r_state <= ST_STATUS;
                    end else begin
                        r_poll_ctr <= r_poll_ctr - 16'd1;
                    end
                end
                ST_STATUS: begin
                    if (rosc_ready) begin
                        if (status_ready(rosc_read_data)) begin
                            r_state <= ST_ENTROPY;
                            r_gap   <= 1'b1;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_poll_ctr <= POLL_CYCLES - 16'd1;
                        end
                    end
                end
                ST_ENTROPY: begin
                    // First ENTROPY cycle is the mandatory cs-low gap after the STATUS read.
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (rosc_ready) begin
                        r_cap_valid <= 1'b1;
                        r_cap_word  <= rosc_read_data;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rosc_cs      = 1'b0;
        rosc_address = ADDR_NONE;
        case (r_state)
            ST_STATUS: begin
                rosc_cs      = 1'b1;
                rosc_address = ADDR_STATUS;
            end
            ST_ENTROPY: begin
                if (!r_gap) begin
                    rosc_cs      = 1'b1;
                    rosc_address = ADDR_ENTROPY;
                end
            end
            default: ;
        endcase
    end

    assign rosc_we         = 1'b0;
    assign rosc_write_data = 32'h0;

    assign w_rep_next = r_rep_ctr + RW'(1);

    always_comb begin
        w_push = 1'b0;
        if (r_cap_valid && (r_discard_ctr == '0)) begin
            w_push = (r_cap_word != r_last_word) || (w_rep_next != c_rep_trip);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_discard_ctr  <= DW'(DISCARD_WORDS);
            r_rep_ctr      <= '0;
            r_last_word    <= '0;
            r_health_error <= 1'b0;
        end else if (r_cap_valid) begin
            if (r_discard_ctr != '0) begin
                r_discard_ctr <= r_discard_ctr - DW'(1);
            end else if (r_cap_word == r_last_word) begin
                r_rep_ctr <= w_rep_next;
                if (w_rep_next == c_rep_trip) begin
                    r_health_error <= 1'b1;
                end
            end else begin
                r_rep_ctr   <= '0;
                r_last_word <= r_cap_word;
            end
        end
    end

    assign health_error = r_health_error;
    assign out_valid    = !w_fifo_empty;

    harvest_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_cap_word),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_rosc_harvester.sv
`default_nettype none
// =============================================================================
// Module   : tb_rosc_harvester
// Brief    : Directed self-checking bench with a behavioural entropy-core model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_rosc_harvester;

    localparam logic [15:0] P = 16'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        rosc_cs, rosc_we, rosc_ready, out_valid, health_error;
    logic        out_ready = 1'b0;
    logic [7:0]  rosc_address;
    logic [31:0] rosc_write_data, rosc_read_data, out_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int cfg_status_zeros = 0;
    int cfg_stat_lat = 0;
    int cfg_ent_lat = 0;
    bit cfg_const = 1'b0;

    rosc_harvester #(
        .POLL_CYCLES   (P),
        .DISCARD_WORDS (2),
        .REP_LIMIT     (3),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .rosc_cs         (rosc_cs),
        .rosc_we         (rosc_we),
        .rosc_address    (rosc_address),
        .rosc_write_data (rosc_write_data),
        .rosc_read_data  (rosc_read_data),
        .rosc_ready      (rosc_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .health_error    (health_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input int idx, input bit is_const);
        if (is_const) return 32'hDEADBEEF;
        case (idx)
            0:       return 32'h11111111;
            1:       return 32'h22222222;
            2:       return 32'h33333333;
            default: return 32'hA0000000 + 32'(idx);
        endcase
    endfunction

    // Entropy core model: ready pulses one cycle after the configured latency.
    int m_zeros, m_wait, m_idx;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rosc_ready     <= 1'b0;
            rosc_read_data <= 32'h0;
            m_zeros        <= cfg_status_zeros;
            m_wait         <= 0;
            m_idx          <= 0;
        end else if (!rosc_cs) begin
            rosc_ready <= 1'b0;
            m_wait     <= 0;
        end else if (rosc_ready) begin
            rosc_ready <= 1'b0;
        end else if (m_wait < ((rosc_address == 8'h09) ? cfg_stat_lat : cfg_ent_lat)) begin
            m_wait <= m_wait + 1;
        end else begin
            rosc_ready <= 1'b1;
            m_wait     <= 0;
            if (rosc_address == 8'h09) begin
                rosc_read_data <= (m_zeros > 0) ? 32'h0 : 32'h1;
                if (m_zeros > 0) m_zeros <= m_zeros - 1;
            end else begin
                rosc_read_data <= word_of(m_idx, cfg_const);
                m_idx          <= m_idx + 1;
            end
        end
    end

    // Bus monitor: access counts, access lengths, idle gaps and protocol violations.
    int   st_reads, en_reads, cs_cycles, viol, gap, min_gap, run, last_st_run, cap_cyc, ov_cyc;
    logic p_cs, p_done, p_ov;
    logic [7:0] p_addr;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            st_reads <= 0; en_reads <= 0; cs_cycles <= 0; viol <= 0; gap <= 0;
            min_gap <= 1000000; run <= 0; last_st_run <= 0; cap_cyc <= 0; ov_cyc <= 0;
            p_cs <= 1'b0; p_done <= 1'b0; p_ov <= 1'b0; p_addr <= 8'h0;
        end else begin
            p_cs   <= rosc_cs;
            p_addr <= rosc_address;
            p_done <= rosc_cs && rosc_ready;
            p_ov   <= out_valid;
            if (out_valid && !p_ov) ov_cyc <= cyc;
            viol <= viol + int'(rosc_we !== 1'b0) + int'(rosc_write_data !== 32'h0)
                  + int'(rosc_cs && p_done)
                  + int'(rosc_cs && p_cs && !p_done && (rosc_address !== p_addr))
                  + int'(rosc_cs && (rosc_address !== 8'h09) && (rosc_address !== 8'h20));
            if (rosc_cs) begin
                cs_cycles <= cs_cycles + 1;
                run <= (p_cs && !p_done) ? run + 1 : 1;
                if (!p_cs && rosc_address == 8'h09 && gap < min_gap) min_gap <= gap;
                gap <= 0;
                if (rosc_ready) begin
                    if (rosc_address == 8'h09) begin
                        st_reads    <= st_reads + 1;
                        last_st_run <= (p_cs && !p_done) ? run + 1 : 1;
                    end else begin
                        en_reads <= en_reads + 1;
                        cap_cyc  <= cyc;
                    end
                end
            end else begin
                gap <= gap + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0; out_ready = 1'b0;
        cfg_status_zeros = 0; cfg_stat_lat = 0; cfg_ent_lat = 0; cfg_const = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (rosc_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", rosc_cs); end
        checks++; if (rosc_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rosc_we); end
        checks++; if (rosc_address !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", rosc_address); end
        checks++; if (rosc_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rosc_write_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (health_error !== 1'b0) begin errors++; $display("FAIL reset_health got=%b exp=0", health_error); end
        reset = 1'b0;
        repeat (3 * P) tick();
        checks++; if (cs_cycles !== 0) begin errors++; $display("FAIL disabled_no_cs got=%0d exp=0", cs_cycles); end
    endtask

    task automatic test_poll_discard();
        cfg_status_zeros = 3;
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 500 && en_reads < 1; i++) tick();
        checks++; if (en_reads !== 1) begin errors++; $display("FAIL poll_first_entropy got=%0d exp=1", en_reads); end
        checks++; if (st_reads !== 4) begin errors++; $display("FAIL poll_status_reads got=%0d exp=4", st_reads); end
        checks++; if (min_gap < int'(P)) begin errors++; $display("FAIL poll_idle_gap got=%0d exp>=%0d", min_gap, P); end
        for (int i = 0; i < 500 && !out_valid; i++) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL discard_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h33333333) begin errors++; $display("FAIL discard_out_data got=%h exp=33333333", out_data); end
        checks++; if (en_reads !== 3) begin errors++; $display("FAIL discard_entropy_reads got=%0d exp=3", en_reads); end
        checks++; if (ov_cyc - cap_cyc !== 2) begin errors++; $display("FAIL push_latency got=%0d exp=2", ov_cyc - cap_cyc); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL poll_bus_protocol got=%0d exp=0", viol); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int c0;
        int k;
        cfg_status_zeros = 0;
        apply_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 800 && en_reads < 6; i++) tick();
        repeat (4 * P) tick();
        checks++; if (en_reads !== 6) begin errors++; $display("FAIL full_entropy_reads got=%0d exp=6", en_reads); end
        c0 = cs_cycles;
        repeat (5 * P) tick();
        checks++; if (cs_cycles !== c0) begin errors++; $display("FAIL full_cs_idle got=%0d exp=%0d", cs_cycles, c0); end
        checks++; if (out_data !== 32'h33333333) begin errors++; $display("FAIL full_head got=%h exp=33333333", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        k = 1;
        checks++; if (out_data !== 32'hA0000003) begin errors++; $display("FAIL pop_next_head got=%h exp=a0000003", out_data); end
        while (!rosc_cs && k < 4 * P) begin tick(); k++; end
        checks++; if (!rosc_cs || k > int'(P) + 2) begin errors++; $display("FAIL resume_latency got=%0d exp<=%0d", k, P + 2); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL full_bus_protocol got=%0d exp=0", viol); end
        enable = 1'b0;
    endtask

    task automatic test_health();
        int c0;
        int npop;
        cfg_const = 1'b1;
        apply_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 800 && !health_error; i++) tick();
        checks++; if (health_error !== 1'b1) begin errors++; $display("FAIL health_set got=%b exp=1", health_error); end
        checks++; if (en_reads !== 5) begin errors++; $display("FAIL health_entropy_reads got=%0d exp=5", en_reads); end
        c0 = cs_cycles;
        repeat (5 * P) tick();
        checks++; if (cs_cycles !== c0) begin errors++; $display("FAIL health_cs_stop got=%0d exp=%0d", cs_cycles, c0); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL health_head got=%h exp=deadbeef", out_data); end
        npop = 0;
        out_ready = 1'b1;
        repeat (6) begin
            if (out_valid) npop++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (npop !== 2) begin errors++; $display("FAIL health_buffered got=%0d exp=2", npop); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL health_drained got=%b exp=0", out_valid); end
        checks++; if (health_error !== 1'b1) begin errors++; $display("FAIL health_sticky got=%b exp=1", health_error); end
        enable = 1'b0; cfg_const = 1'b0;
    endtask

    task automatic test_stall();
        cfg_stat_lat = 4;
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 500 && en_reads < 1; i++) tick();
        checks++; if (last_st_run !== 6) begin errors++; $display("FAIL stall_cs_cycles got=%0d exp=6", last_st_run); end
        checks++; if (st_reads !== 1) begin errors++; $display("FAIL stall_status_reads got=%0d exp=1", st_reads); end
        checks++; if (en_reads !== 1) begin errors++; $display("FAIL stall_single_capture got=%0d exp=1", en_reads); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL stall_bus_stable got=%0d exp=0", viol); end
        enable = 1'b0; out_ready = 1'b0; cfg_stat_lat = 0;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 500 && !out_valid; i++) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_prefill got=%b exp=1", out_valid); end
        cfg_ent_lat = 20;
        for (int i = 0; i < 300 && !(rosc_cs && rosc_address == 8'h20); i++) tick();
        reset = 1'b1;
        #1;
        checks++; if (rosc_cs !== 1'b0) begin errors++; $display("FAIL midrst_cs got=%b exp=0", rosc_cs); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data got=%h exp=0", out_data); end
        cfg_ent_lat = 0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 500 && !out_valid; i++) tick();
        checks++; if (en_reads !== 3) begin errors++; $display("FAIL midrst_discard_restart got=%0d exp=3", en_reads); end
        checks++; if (out_data !== 32'h33333333) begin errors++; $display("FAIL midrst_first_word got=%h exp=33333333", out_data); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_poll_discard();
        test_backpressure();
        test_health();
        test_stall();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
